// File: rtl/flex_counter.sv
// Programmable-rollover up-counter with a registered rollover flag; the count wraps to 1, not 0.
// Optional FLEX_COUNTER_WRAP_CNT_EN adds a saturating 16-bit wrap counter and a one-cycle wrap pulse.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
`ifdef FLEX_COUNTER_WRAP_CNT_EN
    ,
    output logic [15:0]             wrap_count,
    output logic                    wrap_pulse
`endif
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;
    logic [NUM_CNT_BITS-1:0] next_count;

    always_comb begin
        next_count = count_q;
        if (count_enable) begin
            // A zero terminal value parks the counter at 0.
            if (rollover_val == '0)
                next_count = '0;
            else if (count_q >= rollover_val)
                next_count = ONE;
            else
                next_count = count_q + ONE;
        end
        count_d = next_count;
        flag_d  = (next_count == rollover_val) && (rollover_val != '0);
        if (clear) begin
            count_d = '0;
            flag_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;

`ifdef FLEX_COUNTER_WRAP_CNT_EN
    logic        wrap_event;
    logic [15:0] wrap_cnt_q, wrap_cnt_d;
    logic        wrap_pulse_q, wrap_pulse_d;

    always_comb begin
        wrap_event   = count_enable && (rollover_val != '0) && (count_q >= rollover_val);
        wrap_cnt_d   = wrap_cnt_q;
        wrap_pulse_d = 1'b0;
        if (clear) begin
            wrap_cnt_d = '0;
        end else if (wrap_event) begin
            wrap_pulse_d = 1'b1;
            if (wrap_cnt_q != 16'hFFFF)
                wrap_cnt_d = wrap_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrap_cnt_q   <= '0;
            wrap_pulse_q <= 1'b0;
        end else begin
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign wrap_count = wrap_cnt_q;
    assign wrap_pulse = wrap_pulse_q;
`endif

endmodule

// File: tb/tb_flex_counter.sv
// Directed self-checking bench for flex_counter (NUM_CNT_BITS=4).
// Wrap-counter scenario is compiled in only when FLEX_COUNTER_WRAP_CNT_EN is defined.
module tb_flex_counter;

    logic       CLK;
    logic       RST;
    logic       clear;
    logic       count_enable;
    logic [3:0] rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag;
`ifdef FLEX_COUNTER_WRAP_CNT_EN
    logic [15:0] wrap_count;
    logic        wrap_pulse;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    flex_counter #(.NUM_CNT_BITS(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .clear         (clear),
        .count_enable  (count_enable),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag)
`ifdef FLEX_COUNTER_WRAP_CNT_EN
        ,
        .wrap_count    (wrap_count),
        .wrap_pulse    (wrap_pulse)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge, then sample 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        count_enable = 1'b1;
        rollover_val = 4'd5;
        clear        = 1'b0;
        RST          = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if (count_out !== 4'd0 || rollover_flag !== 1'b0)
                $display("FAIL reset_hold cyc%0d: count=%0d flag=%b, need count=0 flag=0", i, count_out, rollover_flag);
            else pass_cnt++;
        end
        RST = 1'b0;
        step();
        total_cnt++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0)
            $display("FAIL reset_release: count=%0d flag=%b, need count=1 flag=0", count_out, rollover_flag);
        else pass_cnt++;
    endtask

    task automatic test_basic_wrap();
        logic [3:0] exp_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2};
        logic       exp_flg [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rollover_val = 4'd5;
        count_enable = 1'b0;
        do_reset();
        count_enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            total_cnt++;
            if (count_out !== exp_seq[i] || rollover_flag !== exp_flg[i])
                $display("FAIL basic_wrap cyc%0d: count=%0d flag=%b, need count=%0d flag=%b",
                         i, count_out, rollover_flag, exp_seq[i], exp_flg[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_clear();
        rollover_val = 4'd5;
        count_enable = 1'b0;
        do_reset();
        count_enable = 1'b1;
        repeat (3) step();
        count_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (count_out !== 4'd3 || rollover_flag !== 1'b0)
                $display("FAIL hold cyc%0d: count=%0d flag=%b, need count=3 flag=0", i, count_out, rollover_flag);
            else pass_cnt++;
        end
        clear        = 1'b1;
        count_enable = 1'b1;
        step();
        total_cnt++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0)
            $display("FAIL clear: count=%0d flag=%b, need count=0 flag=0", count_out, rollover_flag);
        else pass_cnt++;
        clear = 1'b0;
        step();
        total_cnt++;
        if (count_out !== 4'd1)
            $display("FAIL after_clear: count=%0d, need 1", count_out);
        else pass_cnt++;
    endtask

    task automatic test_flag_hold();
        rollover_val = 4'd4;
        count_enable = 1'b0;
        do_reset();
        count_enable = 1'b1;
        repeat (4) step();
        total_cnt++;
        if (count_out !== 4'd4 || rollover_flag !== 1'b1)
            $display("FAIL flag_reach: count=%0d flag=%b, need count=4 flag=1", count_out, rollover_flag);
        else pass_cnt++;
        count_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (count_out !== 4'd4 || rollover_flag !== 1'b1)
                $display("FAIL flag_hold cyc%0d: count=%0d flag=%b, need count=4 flag=1", i, count_out, rollover_flag);
            else pass_cnt++;
        end
        count_enable = 1'b1;
        step();
        total_cnt++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0)
            $display("FAIL flag_release: count=%0d flag=%b, need count=1 flag=0", count_out, rollover_flag);
        else pass_cnt++;
    endtask

    task automatic test_max_rollover();
        rollover_val = 4'd15;
        count_enable = 1'b0;
        do_reset();
        count_enable = 1'b1;
        repeat (14) step();
        total_cnt++;
        if (count_out !== 4'd14 || rollover_flag !== 1'b0)
            $display("FAIL max_14: count=%0d flag=%b, need count=14 flag=0", count_out, rollover_flag);
        else pass_cnt++;
        step();
        total_cnt++;
        if (count_out !== 4'd15 || rollover_flag !== 1'b1)
            $display("FAIL max_15: count=%0d flag=%b, need count=15 flag=1", count_out, rollover_flag);
        else pass_cnt++;
        step();
        total_cnt++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0)
            $display("FAIL max_wrap: count=%0d flag=%b, need count=1 flag=0", count_out, rollover_flag);
        else pass_cnt++;
    endtask

    task automatic test_zero_rollover();
        rollover_val = 4'd0;
        count_enable = 1'b0;
        do_reset();
        count_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (count_out !== 4'd0 || rollover_flag !== 1'b0)
                $display("FAIL zero_park cyc%0d: count=%0d flag=%b, need count=0 flag=0", i, count_out, rollover_flag);
            else pass_cnt++;
        end
        rollover_val = 4'd5;
        repeat (3) step();
        rollover_val = 4'd0;
        step();
        total_cnt++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0)
            $display("FAIL zero_midcount: count=%0d flag=%b, need count=0 flag=0", count_out, rollover_flag);
        else pass_cnt++;
    endtask

    task automatic test_rollover_change();
        rollover_val = 4'd9;
        count_enable = 1'b0;
        do_reset();
        count_enable = 1'b1;
        repeat (6) step();
        total_cnt++;
        if (count_out !== 4'd6)
            $display("FAIL change_pre: count=%0d, need 6", count_out);
        else pass_cnt++;
        rollover_val = 4'd3;
        step();
        total_cnt++;
        if (count_out !== 4'd1 || rollover_flag !== 1'b0)
            $display("FAIL change_wrap: count=%0d flag=%b, need count=1 flag=0", count_out, rollover_flag);
        else pass_cnt++;
        // Stale flag is corrected while enable is low.
        rollover_val = 4'd4;
        repeat (3) step();
        total_cnt++;
        if (count_out !== 4'd4 || rollover_flag !== 1'b1)
            $display("FAIL stale_setup: count=%0d flag=%b, need count=4 flag=1", count_out, rollover_flag);
        else pass_cnt++;
        count_enable = 1'b0;
        rollover_val = 4'd6;
        step();
        total_cnt++;
        if (count_out !== 4'd4 || rollover_flag !== 1'b0)
            $display("FAIL stale_drop: count=%0d flag=%b, need count=4 flag=0", count_out, rollover_flag);
        else pass_cnt++;
        rollover_val = 4'd4;
        step();
        total_cnt++;
        if (count_out !== 4'd4 || rollover_flag !== 1'b1)
            $display("FAIL stale_rise: count=%0d flag=%b, need count=4 flag=1", count_out, rollover_flag);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        rollover_val = 4'd1;
        count_enable = 1'b0;
        do_reset();
        count_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (count_out !== 4'd1 || rollover_flag !== 1'b1)
                $display("FAIL rv1 cyc%0d: count=%0d flag=%b, need count=1 flag=1", i, count_out, rollover_flag);
            else pass_cnt++;
        end
        rollover_val = 4'd7;
        repeat (3) step();
        RST = 1'b1;
        step();
        total_cnt++;
        if (count_out !== 4'd0 || rollover_flag !== 1'b0)
            $display("FAIL mid_reset: count=%0d flag=%b, need count=0 flag=0", count_out, rollover_flag);
        else pass_cnt++;
        RST = 1'b0;
    endtask

`ifdef FLEX_COUNTER_WRAP_CNT_EN
    task automatic test_wrap_count();
        logic exp_pulse [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rollover_val = 4'd2;
        count_enable = 1'b0;
        do_reset();
        total_cnt++;
        if (wrap_count !== 16'd0 || wrap_pulse !== 1'b0)
            $display("FAIL wrap_reset: wrap_count=%0d pulse=%b, need 0/0", wrap_count, wrap_pulse);
        else pass_cnt++;
        count_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total_cnt++;
            if (wrap_pulse !== exp_pulse[i])
                $display("FAIL wrap_pulse cyc%0d: pulse=%b, need %b", i, wrap_pulse, exp_pulse[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (wrap_count !== 16'd4)
            $display("FAIL wrap_total: wrap_count=%0d, need 4", wrap_count);
        else pass_cnt++;
        clear = 1'b1;
        step();
        clear = 1'b0;
        total_cnt++;
        if (wrap_count !== 16'd0)
            $display("FAIL wrap_clear: wrap_count=%0d, need 0", wrap_count);
        else pass_cnt++;
    endtask
`endif

    initial begin
        RST          = 1'b1;
        clear        = 1'b0;
        count_enable = 1'b0;
        rollover_val = 4'd0;
        test_reset();
        test_basic_wrap();
        test_hold_clear();
        test_flag_hold();
        test_max_rollover();
        test_zero_rollover();
        test_rollover_change();
        test_back_to_back();
`ifdef FLEX_COUNTER_WRAP_CNT_EN
        test_wrap_count();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
